// File: rtl/aes_pipe_enc_stream.sv
// rtl/aes_pipe_enc_stream.sv - fully pipelined AES encryptor (one stage per round) with stream handshakes
//
// Purpose: encrypts one 128-bit block per cycle. The pipeline has NR+1 register stages:
//   stage 0 applies AddRoundKey(rk0), stages 1..NR-1 are full rounds, and stage NR omits
//   MixColumns. A valid bit and a sideband tag travel with each block. The whole pipeline
//   freezes while the output is stalled.
// Ports:
//   clk, reset                     single clock, asynchronous active-high reset
//   key_load, key_in, key_ready    key latch request; accepted only when the pipeline is empty
//   in_valid, in_ready, in_data,   plaintext stream input with its sideband tag
//   in_tag
//   out_valid, out_ready,          ciphertext stream output with the unchanged tag
//   out_data, out_tag
//   busy                           OR of all stage valid bits
// Byte order: byte 0 of a block or key is bits [MSB -: 8] (FIPS-197 column-major input order).
module aes_pipe_enc_stream #(
  parameter int KEY_BITS = 128,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_load,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                key_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  localparam int NR  = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10;
  localparam int NK  = KEY_BITS / 32;
  localparam int NW  = 4 * (NR + 1);
  localparam int RKW = 128 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_pipe_enc_stream: KEY_BITS must be 128, 192 or 256");
  end

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit 2047-8x, which is {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Full key schedule; round key r occupies bits [RKW-1-128*r -: 128].
  function automatic logic [RKW-1:0] expand_key(input logic [KEY_BITS-1:0] k);
    logic [31:0]    w [NW];
    logic [31:0]    t;
    logic [7:0]     rc;
    logic [RKW-1:0] rks;
    rc = 8'h01;
    for (int i = 0; i < NK; i++) w[i] = k[KEY_BITS-1-32*i -: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (NK > 6 && i % NK == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    for (int i = 0; i < NW; i++) rks[RKW-1-32*i -: 32] = w[i];
    return rks;
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  logic [KEY_BITS-1:0] key_q;
  logic [RKW-1:0]      rks;
  logic [127:0]        st_q  [NR+1];
  logic [TAG_W-1:0]    tag_q [NR+1];
  logic [NR:0]         vld_q;
  logic                stall;
  logic                accept;

  // Key only changes with the pipeline empty, so one combinational schedule serves every stage.
  assign rks       = expand_key(key_q);
  assign stall     = vld_q[NR] && !out_ready;
  assign busy      = |vld_q;
  assign key_ready = !busy;
  assign in_ready  = !stall && !key_load;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_q[NR];
  assign out_data  = st_q[NR];
  assign out_tag   = tag_q[NR];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q <= '0;
      vld_q <= '0;
      for (int i = 0; i <= NR; i++) begin
        st_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      if (key_load && key_ready) key_q <= key_in;
      // Without a stall every stage advances; a non-accepted cycle injects a bubble.
      if (!stall) begin
        vld_q    <= {vld_q[NR-1:0], accept};
        st_q[0]  <= in_data ^ rks[RKW-1 -: 128];
        tag_q[0] <= in_tag;
        for (int i = 1; i <= NR; i++) begin
          st_q[i]  <= aes_round(st_q[i-1], rks[RKW-1-128*i -: 128], i == NR);
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_pipe_enc_stream.sv
// tb/tb_aes_pipe_enc_stream.sv - self-checking bench for aes_pipe_enc_stream (128/192/256-bit instances)
module tb_aes_pipe_enc_stream;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [2:0]     kl, iv, kr, ir, ov, bz;
  logic [255:0]   key [3];
  logic [127:0]   din;
  logic [TW-1:0]  tin;
  logic           ordy;
  logic [127:0]   od [3];
  logic [TW-1:0]  ot [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]        sbt [256];
  logic [TW+127:0]   sbq [$];
  logic [255:0]      cur_key, fk, newk;
  logic [127:0]      fct [3];
  logic              rnd;
  logic              prev_stall = 1'b0;
  logic [127:0]      prev_d;
  logic [TW-1:0]     prev_t;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_pipe_enc_stream #(.KEY_BITS(128 + 64*g), .TAG_W(TW)) dut (
      .clk(clk), .reset(reset),
      .key_load(kl[g]), .key_in(key[g][255 -: 128 + 64*g]), .key_ready(kr[g]),
      .in_valid(iv[g]), .in_ready(ir[g]), .in_data(din), .in_tag(tin),
      .out_valid(ov[g]), .out_ready(ordy), .out_data(od[g]), .out_tag(ot[g]),
      .busy(bz[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Reference AES: 4x4 state matrix, key left-aligned in 256 bits.
  function automatic logic [127:0] model_enc(input logic [255:0] k, input int kbits,
                                             input logic [127:0] pt);
    int nk, nr;
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] ct;
    nk = kbits / 32; nr = nk + 6; rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = {sbt[tmp[31:24]], sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]]};
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbt[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rd < nr) s[r][c] = gm(t[r][c], 8'h02) ^ gm(t[(r+1)%4][c], 8'h03)
                                 ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else         s[r][c] = t[r][c];
          s[r][c] ^= w[4*rd+c][31-8*r -: 8];
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ct[127-8*(r+4*c) -: 8] = s[r][c];
    return ct;
  endfunction

  // Scoreboard monitor for the 128-bit instance; also checks output hold under stall.
  always @(negedge clk) begin
    logic [TW+127:0] e;
    if (prev_stall) begin
      chk("hold_data", od[0], prev_d);
      chk("hold_tag", 128'(ot[0]), 128'(prev_t));
    end
    prev_stall = ov[0] && !ordy;
    prev_d = od[0];
    prev_t = ot[0];
    if (ov[0] && ordy) begin
      chk("sb_nonempty", 128'(sbq.size() > 0), 128'(1));
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("out_data", od[0], e[127:0]);
        chk("out_tag", 128'(ot[0]), 128'(e[TW+127:128]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rnd) ordy = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [127:0] d, input logic [TW-1:0] t);
    int n;
    n = 0;
    din = d; tin = t; iv[0] = 1'b1;
    @(negedge clk);
    while (!ir[0] && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", 128'(ir[0]), 128'(1));
    if (ir[0]) sbq.push_back({t, model_enc(cur_key, 128, d)});
    tick();
    iv[0] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bz[0] && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_busy", 128'(bz[0]), 128'(0));
    chk("drain_sb_empty", 128'(sbq.size()), 128'(0));
  endtask

  task automatic fips(input int g);
    int lat;
    key[g] = fk; kl[g] = 1'b1;
    @(negedge clk);
    chk("fips_key_ready", 128'(kr[g]), 128'(1));
    tick();
    kl[g] = 1'b0;
    if (g == 0) cur_key = fk;
    din = 128'h00112233445566778899aabbccddeeff; tin = 4'h5; iv[g] = 1'b1;
    @(negedge clk);
    chk("fips_in_ready", 128'(ir[g]), 128'(1));
    if (g == 0) sbq.push_back({tin, model_enc(cur_key, 128, din)});
    tick();
    iv[g] = 1'b0;
    lat = 1;
    while (!ov[g] && lat < 40) begin
      tick();
      lat++;
    end
    chk("fips_latency", 128'(lat), 128'(11 + 2*g));
    chk("fips_ct", od[g], fct[g]);
    chk("fips_tag", 128'(ot[g]), 128'(4'h5));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ov;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
    for (int b = 0; b < 32; b++) fk[255-8*b -: 8] = 8'(b);
    fct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    fct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    fct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;

    reset = 1'b1; kl = '0; iv = '0; din = '0; tin = '0; ordy = 1'b1; rnd = 1'b0;
    cur_key = '0; newk = '0;
    for (int g = 0; g < 3; g++) key[g] = '0;

    // Reset state on every instance.
    #12;
    for (int g = 0; g < 3; g++) begin
      chk("rst_out_valid", 128'(ov[g]), 128'(0));
      chk("rst_busy", 128'(bz[g]), 128'(0));
      chk("rst_key_ready", 128'(kr[g]), 128'(1));
      chk("rst_in_ready", 128'(ir[g]), 128'(1));
      chk("rst_out_data", od[g], 128'h0);
      chk("rst_out_tag", 128'(ot[g]), 128'(0));
    end
    tick();
    reset = 1'b0;

    // Known-answer vectors with exact latency for all three key sizes.
    for (int g = 0; g < 3; g++) fips(g);

    // Back-to-back stream with random backpressure.
    rnd = 1'b1;
    for (int i = 0; i < 20; i++) send({$urandom, $urandom, $urandom, $urandom}, 4'(i));
    drain();
    rnd = 1'b0; ordy = 1'b1;

    // key_load while busy is ignored; in-flight blocks keep the old key.
    newk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    send(128'h0123456789abcdeffedcba9876543210, 4'ha);
    key[0] = newk; kl[0] = 1'b1;
    @(negedge clk);
    chk("busy_key_ready", 128'(kr[0]), 128'(0));
    chk("keyload_in_ready", 128'(ir[0]), 128'(0));
    tick();
    kl[0] = 1'b0;
    send(128'hffeeddccbbaa99887766554433221100, 4'hb);
    drain();

    // Same-cycle key_load and in_valid on an empty pipeline.
    din = 128'hdeadbeef00000000cafef00d12345678; tin = 4'hc; iv[0] = 1'b1; kl[0] = 1'b1;
    @(negedge clk);
    chk("same_cycle_in_ready", 128'(ir[0]), 128'(0));
    chk("same_cycle_key_ready", 128'(kr[0]), 128'(1));
    tick();
    kl[0] = 1'b0;
    cur_key = newk;
    send(128'hdeadbeef00000000cafef00d12345678, 4'hc);
    drain();

    // Reset with five blocks in flight.
    for (int i = 0; i < 5; i++) send({$urandom, $urandom, $urandom, $urandom}, 4'(i + 3));
    chk("busy_before_reset", 128'(bz[0]), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("reset_out_valid", 128'(ov[0]), 128'(0));
    chk("reset_busy", 128'(bz[0]), 128'(0));
    chk("reset_out_data", od[0], 128'h0);
    chk("reset_key_ready", 128'(kr[0]), 128'(1));
    sbq.delete();
    cur_key = '0;
    prev_stall = 1'b0;
    tick();
    reset = 1'b0;
    n_ov = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov[0]) n_ov++;
    end
    chk("no_out_after_reset", 128'(n_ov), 128'(0));
    tick();
    // Key register was cleared, so this block is encrypted under the all-zero key.
    send(128'h00000000000000000000000000000001, 4'h7);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
